// File: rtl/param_prom_emul.sv
// param_prom_emul: parameter-PROM responder for standalone/loopback builds.
// Streams a locally written byte image on PARAM_DAT under reader PROM controls.
module param_prom_emul #(
  parameter int ADDR_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              PARAM_CLK,
  input  logic              PARAM_CE_B,
  input  logic              PARAM_OE,
  output logic [7:0]        PARAM_DAT,
  output logic              DAT_OE,
  input  logic              WR_EN,
  input  logic [ADDR_W-1:0] WR_ADDR,
  input  logic [7:0]        WR_DATA,
  output logic [ADDR_W:0]   BYTE_CNT,
  output logic              WRAP,
  output logic              ACTIVE
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    STREAM
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] ce_sync;
  logic [SYNC_STAGES-1:0] oe_sync;
  logic [SYNC_STAGES-1:0] pclk_sync;
  logic                   pclk_d;
  logic                   ce_s, oe_s, pclk_s, rise;

  logic [ADDR_W-1:0] addr, addr_nxt;
  logic [ADDR_W:0]   cnt_nxt;
  logic              wrap_nxt;
  logic [7:0]        rd_data;
  logic [7:0]        mem [DEPTH];

  // CE is inverted ahead of the synchronizer so a reset chain reads as deasserted
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ce_sync   <= '0;
      oe_sync   <= '0;
      pclk_sync <= '0;
      pclk_d    <= 1'b0;
    end else begin
      ce_sync   <= {ce_sync[SYNC_STAGES-2:0], ~PARAM_CE_B};
      oe_sync   <= {oe_sync[SYNC_STAGES-2:0], PARAM_OE};
      pclk_sync <= {pclk_sync[SYNC_STAGES-2:0], PARAM_CLK};
      pclk_d    <= pclk_s;
    end
  end

  assign ce_s   = ce_sync[SYNC_STAGES-1];
  assign oe_s   = oe_sync[SYNC_STAGES-1];
  assign pclk_s = pclk_sync[SYNC_STAGES-1];
  assign rise   = pclk_s & ~pclk_d;

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    cnt_nxt   = BYTE_CNT;
    wrap_nxt  = WRAP;
    unique case (state)
      IDLE: begin
        if (ce_s) state_nxt = ARMED;
      end
      ARMED: begin
        if (!ce_s)     state_nxt = IDLE;
        else if (oe_s) state_nxt = STREAM;
      end
      STREAM: begin
        if (!ce_s) begin
          state_nxt = IDLE;
        end else if (!oe_s) begin
          state_nxt = ARMED;
        end else if (rise) begin
          addr_nxt = addr + ADDR_W'(1);
          if (BYTE_CNT != CNT_MAX) cnt_nxt = BYTE_CNT + (ADDR_W+1)'(1);
          if (addr == ADDR_MAX) wrap_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Leaving CE wins over any same-cycle edge
    if (state_nxt == IDLE) begin
      addr_nxt = '0;
      cnt_nxt  = '0;
      wrap_nxt = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      addr     <= '0;
      BYTE_CNT <= '0;
      WRAP     <= 1'b0;
      DAT_OE   <= 1'b0;
      rd_data  <= 8'h00;
    end else begin
      state    <= state_nxt;
      addr     <= addr_nxt;
      BYTE_CNT <= cnt_nxt;
      WRAP     <= wrap_nxt;
      DAT_OE   <= (state_nxt == STREAM);
      rd_data  <= mem[addr];
    end
  end

  always_ff @(posedge CLK) begin
    if (WR_EN) mem[WR_ADDR] <= WR_DATA;
  end

  assign PARAM_DAT = DAT_OE ? rd_data : 8'h00;
  assign ACTIVE    = (state != IDLE);

endmodule

// File: tb/tb_param_prom_emul.sv
// tb_param_prom_emul: reader-side stimulus for param_prom_emul.
// Expected bytes come from an image array indexed by PROM edge count.
module tb_param_prom_emul;

  logic       clk = 1'b0;
  logic       rst;
  logic       pclk, ce_b, oe;
  logic [7:0] param_dat;
  logic       dat_oe;
  logic       wr_en;
  logic [7:0] wr_addr, wr_data;
  logic [8:0] byte_cnt;
  logic       wrap, active;

  int total = 0;
  int bad   = 0;
  int n     = 0;
  logic [7:0] img [256];

  always #5 clk = ~clk;

  param_prom_emul #(.ADDR_W(8), .SYNC_STAGES(2)) dut (
    .CLK        (clk),
    .RST        (rst),
    .PARAM_CLK  (pclk),
    .PARAM_CE_B (ce_b),
    .PARAM_OE   (oe),
    .PARAM_DAT  (param_dat),
    .DAT_OE     (dat_oe),
    .WR_EN      (wr_en),
    .WR_ADDR    (wr_addr),
    .WR_DATA    (wr_data),
    .BYTE_CNT   (byte_cnt),
    .WRAP       (wrap),
    .ACTIVE     (active)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic write_byte(input int a, input int d);
    wr_en   = 1'b1;
    wr_addr = 8'(a);
    wr_data = 8'(d);
    @(negedge clk);
    wr_en = 1'b0;
    img[a] = 8'(d);
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_dat"}, param_dat, 0);
    chk({tag, "_oe"}, dat_oe, 0);
    chk({tag, "_cnt"}, byte_cnt, 0);
    chk({tag, "_wrap"}, wrap, 0);
    chk({tag, "_act"}, active, 0);
  endtask

  task automatic start_access;
    ce_b = 1'b0;
    oe   = 1'b1;
    cyc(6);
    n = 0;
    chk("dat_oe_on", dat_oe, 1);
    chk("active_on", active, 1);
  endtask

  task automatic end_access;
    ce_b = 1'b1;
    oe   = 1'b0;
    cyc(5);
    n = 0;
    chk_idle_outs("idle");
  endtask

  // Reader samples the bus on its rising edge, then drives the edge
  task automatic pulse(input int hi, input int lo);
    chk($sformatf("byte%0d", n), param_dat, img[n % 256]);
    pclk = 1'b1;
    n++;
    cyc(hi);
    pclk = 1'b0;
    cyc(lo);
  endtask

  task automatic stream(input int k);
    repeat (k) pulse(5, 5);
  endtask

  task automatic check_counts;
    chk("byte_cnt", byte_cnt, (n > 256) ? 256 : n);
    chk("wrap", wrap, (n >= 256) ? 1 : 0);
  endtask

  task automatic lat_pulse;
    logic [7:0] old_b, new_b;
    old_b = img[n % 256];
    new_b = img[(n + 1) % 256];
    chk("lat_sample", param_dat, old_b);
    pclk = 1'b1;
    n++;
    cyc(3);
    chk("lat3_old", param_dat, old_b);
    cyc(1);
    chk("lat4_new", param_dat, new_b);
    cyc(1);
    pclk = 1'b0;
    cyc(5);
  endtask

  initial begin
    rst = 1'b1;
    pclk = 1'b0;
    ce_b = 1'b1;
    oe = 1'b0;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    cyc(2);
    chk_idle_outs("reset");
    rst = 1'b0;
    cyc(2);

    for (int i = 0; i < 256; i++) write_byte(i, i ^ 8'hA5);
    chk_idle_outs("load");

    // ten edges, first one with latency probes
    start_access;
    lat_pulse;
    stream(9);
    check_counts;
    end_access;

    // wrap and saturation
    start_access;
    stream(257);
    check_counts;
    end_access;

    // output-enable gap with PROM clock toggling
    start_access;
    stream(5);
    oe = 1'b0;
    cyc(4);
    chk("gap_oe", dat_oe, 0);
    chk("gap_dat", param_dat, 0);
    chk("gap_act", active, 1);
    repeat (2) begin
      pclk = 1'b1;
      cyc(4);
      pclk = 1'b0;
      cyc(4);
    end
    chk("gap_cnt", byte_cnt, 5);
    chk("gap_oe2", dat_oe, 0);
    oe = 1'b1;
    cyc(6);
    chk("resume_oe", dat_oe, 1);
    stream(3);
    check_counts;

    // read-after-write on the presented address
    begin
      logic [7:0] old_b;
      int a;
      a = n % 256;
      old_b = img[a];
      wr_en = 1'b1;
      wr_addr = 8'(a);
      wr_data = 8'h3C;
      @(negedge clk);
      wr_en = 1'b0;
      chk("raw_old", param_dat, old_b);
      cyc(1);
      chk("raw_new", param_dat, 8'h3C);
      img[a] = 8'h3C;
    end
    stream(2);
    end_access;

    // asynchronous reset mid-stream
    start_access;
    stream(7);
    rst = 1'b1;
    #1;
    chk("arst_dat", param_dat, 0);
    chk("arst_oe", dat_oe, 0);
    chk("arst_cnt", byte_cnt, 0);
    chk("arst_wrap", wrap, 0);
    chk("arst_act", active, 0);
    cyc(2);
    rst = 1'b0;
    cyc(6);
    n = 0;
    chk("post_rst_oe", dat_oe, 1);
    stream(4);
    check_counts;
    end_access;

    // CE release coincident with a PROM clock rise
    start_access;
    stream(6);
    ce_b = 1'b1;
    pclk = 1'b1;
    cyc(5);
    chk("ce_win_cnt", byte_cnt, 0);
    chk("ce_win_act", active, 0);
    chk("ce_win_wrap", wrap, 0);
    pclk = 1'b0;
    cyc(3);
    start_access;
    stream(3);
    check_counts;
    end_access;

    // randomized image, lengths, widths and background writes
    for (int i = 0; i < 256; i++) write_byte(i, $urandom_range(0, 255));
    for (int t = 0; t < 3; t++) begin
      int k;
      k = $urandom_range(1, 300);
      start_access;
      for (int j = 0; j < k; j++) begin
        pulse($urandom_range(4, 7), $urandom_range(4, 7));
        if ($urandom_range(0, 3) == 0) begin
          write_byte($urandom_range(0, 255), $urandom_range(0, 255));
          cyc(1);
        end
      end
      check_counts;
      end_access;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/param_prom_emul.md
# param_prom_emul

PROM responder for the DCFEB parameter-PROM interface. It stands in for the external parameter PROM in standalone and loopback test builds. It holds a byte image written by local logic. It streams that image onto the 8-bit parameter data bus in response to the PROM controls driven by the FPGA-side reader: PARAM_CLK, PARAM_CE_B and PARAM_OE. All logic runs on one system clock; the PROM controls are treated as asynchronous inputs and synchronized internally.

## Interface
- ADDR_W, 8: image address width; depth = 2^ADDR_W bytes.
- SYNC_STAGES, 2: flip-flop stages on each PROM control input; legal values are 2 or 3.
- CLK  in  1  system clock; must be ≥ 8× PARAM_CLK frequency.
- RST  in  1  asynchronous reset, active-high.
- PARAM_CLK  in  1  PROM clock from the reader; asynchronous to CLK.
- PARAM_CE_B  in  1  chip enable from the reader, active-low; asynchronous to CLK.
- PARAM_OE  in  1  output enable from the reader, active-high; asynchronous to CLK.
- PARAM_DAT  out  8  PROM data to the reader.
- DAT_OE  out  1  tristate enable for the PARAM_DAT pad buffer.
- WR_EN  in  1  image write strobe.
- WR_ADDR  in  ADDR_W  image write address.
- WR_DATA  in  8  image write data.
- BYTE_CNT  out  ADDR_W+1  number of bytes advanced since the last chip-enable assertion.
- WRAP  out  1  sticky flag: the address wrapped during the current access.
- ACTIVE  out  1  high in the ARMED and STREAM states.

## Operation
- Image storage:
  - 2^ADDR_W × 8 memory; one write port and one registered read port.
  - A WR_EN cycle writes WR_DATA to WR_ADDR. Writes are allowed in every state.
  - Memory contents are not cleared by RST.
- Synchronization and edge detection:
  - Each PROM control passes through SYNC_STAGES flip-flops. The synchronized versions are ce_s, oe_s and pclk_s.
  - A one-bit history register on pclk_s gives rise = pclk_s & ~pclk_d.
- State machine, evaluated each CLK:
  - IDLE: ce_s deasserted (PARAM_CE_B high). Hold addr=0, BYTE_CNT=0, WRAP=0. Go to ARMED when PARAM_CE_B goes low.
  - ARMED: CE asserted, oe_s low. Edges are ignored and addr holds. Go to STREAM when oe_s goes high. Go to IDLE when CE deasserts.
  - STREAM: on each rise, addr <= addr+1 (mod 2^ADDR_W) and BYTE_CNT <= BYTE_CNT+1, saturating at 2^ADDR_W. Go to ARMED when oe_s goes low; addr is kept. Go to IDLE when CE deasserts.
  - If CE deassertion and a rise occur in the same cycle, CE wins: addr is reset and there is no increment.
- Wrap: a rise while addr = 2^ADDR_W−1 sets addr to 0 and sets WRAP. WRAP clears only in IDLE or on RST.
- Data output:
  - rd_data <= mem[addr] every cycle.
  - PARAM_DAT = rd_data when DAT_OE is high, else 8'h00.
  - DAT_OE is registered: high in STREAM, low otherwise.
- Read-after-write: a write to the address currently presented appears on PARAM_DAT on the second cycle after the write. The cycle in between still shows the old byte.

## Timing
- Reset values: PARAM_DAT=8'h00, DAT_OE=0, BYTE_CNT=0, WRAP=0, ACTIVE=0, state=IDLE, addr=0. All synchronizer and history flip-flops reset to 0.
- Edge-to-data latency:
  - The external PARAM_CLK rising edge reaches rise after SYNC_STAGES+1 CLK cycles.
  - addr updates on the same clock edge that consumes rise.
  - PARAM_DAT changes one CLK later.
  - Total: SYNC_STAGES+2 CLK cycles, which is 4 for the default.
- Byte order: byte k of the image is on PARAM_DAT after k PROM clock rising edges in STREAM. The reader samples byte 0 on its first rising edge.
- Minimum PARAM_CLK high and low time is 4 CLK periods. Narrower pulses may be missed; this is not detected.
- CE/OE to DAT_OE: DAT_OE follows a PARAM_OE change after SYNC_STAGES+1 cycles. It drops in the same cycle as the transition to IDLE.

## Test plan
- Load image mem[i]=i^8'hA5 for all 256 bytes. Hold CE_B=0, OE=1 and give 10 PARAM_CLK edges at CLK/10 → bytes A5,A4,A7,... are sampled in order; BYTE_CNT=10; WRAP=0.
- Stream 257 edges → the 257th sample equals mem[0]=A5 again; WRAP=1; BYTE_CNT saturates at 256. Then deassert CE_B → WRAP=0 and BYTE_CNT=0.
- After 5 edges, drop OE for 20 CLK while toggling PARAM_CLK, then raise OE → DAT_OE=0 and PARAM_DAT=00 during the gap; streaming resumes at byte 5; edges during the gap are not counted.
- Assert RST during STREAM → all outputs are at their reset values within 1 CLK (asynchronous). After release with CE_B still 0, the block goes IDLE→ARMED/STREAM and starts at byte 0.
- Write 8'h3C to the currently presented address mid-stream → the old byte is shown the cycle after the write and 3C on the second cycle.
- Deassert CE_B in the same synchronized cycle as a PARAM_CLK rise → no increment; addr=0; the next access starts at byte 0.
